// File: rtl/alu_ctrl_generator.sv
// Registered RV32I opcode/funct3/funct7 decoder producing the ALU operation code and datapath strobes.
// Optional ILLEGAL_COUNT_EN adds a saturating 16-bit count of illegal decodes.
module alu_ctrl_generator #(
  parameter logic [3:0] INVALID_CODE = 4'b1111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [3:0]  alu_control,
  output logic        illegal,
  output logic        reg_write,
  output logic        alu_src_imm,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        jump,
`ifdef ILLEGAL_COUNT_EN
  output logic [15:0] illegal_count,
`endif
  output logic        out_valid
);

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  logic [3:0] dec_code;
  logic       dec_ok;
  logic       dec_reg_write;
  logic       dec_imm;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       dec_branch;
  logic       dec_jump;

  always_comb begin
    dec_code      = ALU_ADD;
    dec_ok        = 1'b0;
    dec_reg_write = 1'b0;
    dec_imm       = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_jump      = 1'b0;

    case (opcode)
      OP_R: begin
        dec_reg_write = 1'b1;
        if (funct7 == 7'h00) begin
          dec_ok = 1'b1;
          case (funct3)
            3'b000:  dec_code = ALU_ADD;
            3'b001:  dec_code = ALU_SLL;
            3'b010:  dec_code = ALU_SLT;
            3'b011:  dec_code = ALU_SLTU;
            3'b100:  dec_code = ALU_XOR;
            3'b101:  dec_code = ALU_SRL;
            3'b110:  dec_code = ALU_OR;
            default: dec_code = ALU_AND;
          endcase
        end else if (funct7 == 7'h20) begin
          if (funct3 == 3'b000) begin
            dec_ok   = 1'b1;
            dec_code = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            dec_ok   = 1'b1;
            dec_code = ALU_SRA;
          end
        end
      end
      OP_I: begin
        dec_reg_write = 1'b1;
        dec_imm       = 1'b1;
        dec_ok        = 1'b1;
        case (funct3)
          3'b000: dec_code = ALU_ADD;
          3'b001: begin
            dec_code = ALU_SLL;
            dec_ok   = (funct7 == 7'h00);
          end
          3'b010: dec_code = ALU_SLT;
          3'b011: dec_code = ALU_SLTU;
          3'b100: dec_code = ALU_XOR;
          3'b101: begin
            dec_code = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
            dec_ok   = (funct7 == 7'h00) || (funct7 == 7'h20);
          end
          3'b110:  dec_code = ALU_OR;
          default: dec_code = ALU_AND;
        endcase
      end
      OP_LOAD: begin
        dec_reg_write = 1'b1;
        dec_imm       = 1'b1;
        dec_mem_read  = 1'b1;
        dec_ok        = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      end
      OP_STORE: begin
        dec_imm       = 1'b1;
        dec_mem_write = 1'b1;
        dec_ok        = (funct3 <= 3'b010);
      end
      OP_BRANCH: begin
        dec_branch = 1'b1;
        dec_ok     = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_code = ALU_SUB;
          3'b100, 3'b101: dec_code = ALU_SLT;
          3'b110, 3'b111: dec_code = ALU_SLTU;
          default:        dec_ok   = 1'b0;
        endcase
      end
      OP_LUI: begin
        dec_ok        = 1'b1;
        dec_code      = ALU_PASS_B;
        dec_reg_write = 1'b1;
        dec_imm       = 1'b1;
      end
      OP_AUIPC: begin
        dec_ok        = 1'b1;
        dec_reg_write = 1'b1;
        dec_imm       = 1'b1;
      end
      OP_JAL: begin
        dec_ok        = 1'b1;
        dec_reg_write = 1'b1;
        dec_jump      = 1'b1;
      end
      OP_JALR: begin
        dec_ok        = (funct3 == 3'b000);
        dec_reg_write = 1'b1;
        dec_imm       = 1'b1;
        dec_jump      = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase

    // Strobes are set optimistically above; an illegal decode squashes them all here.
    if (!dec_ok) begin
      dec_code      = INVALID_CODE;
      dec_reg_write = 1'b0;
      dec_imm       = 1'b0;
      dec_mem_read  = 1'b0;
      dec_mem_write = 1'b0;
      dec_branch    = 1'b0;
      dec_jump      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_control <= INVALID_CODE;
      illegal     <= 1'b0;
      reg_write   <= 1'b0;
      alu_src_imm <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
      jump        <= 1'b0;
      out_valid   <= 1'b0;
    end else if (in_valid) begin
      alu_control <= dec_code;
      illegal     <= !dec_ok;
      reg_write   <= dec_reg_write;
      alu_src_imm <= dec_imm;
      mem_read    <= dec_mem_read;
      mem_write   <= dec_mem_write;
      branch      <= dec_branch;
      jump        <= dec_jump;
      out_valid   <= 1'b1;
    end else begin
      out_valid   <= 1'b0;
    end
  end

`ifdef ILLEGAL_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_count <= '0;
    end else if (in_valid && !dec_ok && (illegal_count != '1)) begin
      illegal_count <= illegal_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_generator.sv
// Directed plus randomized checks of alu_ctrl_generator against a table-driven reference decoder.
module tb_alu_ctrl_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [6:0] funct7 = '0;
  logic [3:0] alu_control;
  logic       illegal, reg_write, alu_src_imm, mem_read, mem_write, branch, jump, out_valid;
`ifdef ILLEGAL_COUNT_EN
  logic [15:0] illegal_count;
  logic [15:0] exp_cnt = '0;
`endif

  alu_ctrl_generator #(.INVALID_CODE(4'b1111)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_control(alu_control), .illegal(illegal), .reg_write(reg_write),
    .alu_src_imm(alu_src_imm), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .jump(jump),
`ifdef ILLEGAL_COUNT_EN
    .illegal_count(illegal_count),
`endif
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // {code, illegal, reg_write, imm, mem_read, mem_write, branch, jump}
  typedef struct packed {
    logic [3:0] code;
    logic ill, rw, imm, mr, mw, br, j;
  } dec_t;

  int unsigned errors = 0;
  int unsigned checks = 0;
  dec_t exp_d;
  logic exp_ov;

  // funct7=0 R-type / I-type operation code indexed by funct3
  logic [3:0] base_code [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9};

  function automatic dec_t legal(input logic [3:0] c, input logic rw, imm, mr, mw, br, j);
    dec_t d;
    d.code = c; d.ill = 1'b0; d.rw = rw; d.imm = imm;
    d.mr = mr; d.mw = mw; d.br = br; d.j = j;
    return d;
  endfunction

  function automatic dec_t ref_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    dec_t d;
    int f = int'(f3);
    d = '0;
    d.code = 4'hF;
    d.ill = 1'b1;
    if (op == 7'h33) begin
      if (f7 == 7'h00) d = legal(base_code[f], 1, 0, 0, 0, 0, 0);
      else if (f7 == 7'h20 && f == 0) d = legal(4'h1, 1, 0, 0, 0, 0, 0);
      else if (f7 == 7'h20 && f == 5) d = legal(4'h7, 1, 0, 0, 0, 0, 0);
    end else if (op == 7'h13) begin
      if (f == 1 || f == 5) begin
        if (f7 == 7'h00) d = legal(base_code[f], 1, 1, 0, 0, 0, 0);
        else if (f7 == 7'h20 && f == 5) d = legal(4'h7, 1, 1, 0, 0, 0, 0);
      end else d = legal(base_code[f], 1, 1, 0, 0, 0, 0);
    end else if (op == 7'h03) begin
      if (f inside {0, 1, 2, 4, 5}) d = legal(4'h0, 1, 1, 1, 0, 0, 0);
    end else if (op == 7'h23) begin
      if (f < 3) d = legal(4'h0, 0, 1, 0, 1, 0, 0);
    end else if (op == 7'h63) begin
      if (f < 2) d = legal(4'h1, 0, 0, 0, 0, 1, 0);
      else if (f == 4 || f == 5) d = legal(4'h3, 0, 0, 0, 0, 1, 0);
      else if (f >= 6) d = legal(4'h4, 0, 0, 0, 0, 1, 0);
    end else if (op == 7'h37) d = legal(4'hA, 1, 1, 0, 0, 0, 0);
    else if (op == 7'h17) d = legal(4'h0, 1, 1, 0, 0, 0, 0);
    else if (op == 7'h6F) d = legal(4'h0, 1, 0, 0, 0, 0, 1);
    else if (op == 7'h67) begin
      if (f == 0) d = legal(4'h0, 1, 1, 0, 0, 0, 1);
    end
    return d;
  endfunction

  task automatic step(input logic rst, input logic v, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input string tag);
    logic [11:0] obs, expv;
    dec_t nd;
    @(negedge clk);
    rst_n = rst; in_valid = v; opcode = op; funct3 = f3; funct7 = f7;
    nd = ref_decode(op, f3, f7);
    @(posedge clk);
    if (!rst) begin
      exp_d = '0; exp_d.code = 4'hF; exp_ov = 1'b0;
`ifdef ILLEGAL_COUNT_EN
      exp_cnt = '0;
`endif
    end else if (v) begin
`ifdef ILLEGAL_COUNT_EN
      if (nd.ill && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
      exp_d = nd; exp_ov = 1'b1;
    end else exp_ov = 1'b0;
    #1;
    obs  = {alu_control, illegal, reg_write, alu_src_imm, mem_read, mem_write, branch, jump, out_valid};
    expv = {exp_d, exp_ov};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
    end
`ifdef ILLEGAL_COUNT_EN
    checks++;
    assert (illegal_count === exp_cnt) else begin
      errors++;
      $error("FAIL %s_count: observed=%0d expected=%0d", tag, illegal_count, exp_cnt);
    end
`endif
  endtask

  logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};

  initial begin
    exp_d = '0; exp_d.code = 4'hF; exp_ov = 1'b0;
    step(0, 0, '0, '0, '0, "reset0");
    step(0, 0, '0, '0, '0, "reset1");
    step(1, 1, 7'h33, 3'b000, 7'h20, "r_sub");
    for (int i = 0; i < 8; i++) step(1, 1, 7'h33, 3'(i), 7'h00, "r_sweep");
    step(1, 1, 7'h33, 3'b001, 7'h20, "r_bad_f7");
    step(1, 1, 7'h13, 3'b101, 7'h20, "i_srai");
    step(1, 1, 7'h13, 3'b101, 7'h10, "i_bad_shift");
    step(1, 1, 7'h13, 3'b001, 7'h20, "i_bad_slli");
    step(1, 1, 7'h13, 3'b000, 7'h55, "i_addi_f7");
    step(1, 1, 7'h03, 3'b010, 7'h00, "lw");
    step(1, 1, 7'h03, 3'b011, 7'h00, "ld_bad");
    step(1, 1, 7'h23, 3'b010, 7'h00, "sw");
    step(1, 1, 7'h63, 3'b110, 7'h00, "bltu");
    step(1, 1, 7'h63, 3'b010, 7'h00, "br_bad");
    step(1, 1, 7'h37, 3'b011, 7'h7F, "lui");
    step(1, 1, 7'h17, 3'b000, 7'h00, "auipc");
    step(1, 1, 7'h6F, 3'b111, 7'h00, "jal");
    step(1, 1, 7'h67, 3'b001, 7'h00, "jalr_bad");
    step(1, 1, 7'h67, 3'b000, 7'h00, "jalr");
    step(1, 1, 7'h7F, 3'b000, 7'h00, "op_bad");
    step(1, 1, 7'h33, 3'b000, 7'h00, "add");
    step(1, 0, 7'h63, 3'b010, 7'h00, "hold");
    step(1, 0, 7'h7F, 3'b000, 7'h00, "hold2");
    step(0, 1, 7'h33, 3'b000, 7'h00, "rst_priority");
    step(1, 1, 7'h7F, 3'b000, 7'h00, "cnt_ill1");
    step(1, 1, 7'h33, 3'b011, 7'h20, "cnt_ill2");
    step(1, 0, 7'h7F, 3'b000, 7'h00, "cnt_idle");
    step(1, 1, 7'h63, 3'b011, 7'h00, "cnt_ill3");
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op, f7;
      int unsigned sel = $urandom_range(0, 9);
      int unsigned f7s = $urandom_range(0, 3);
      op = (sel == 9) ? 7'($urandom) : ops[sel];
      f7 = (f7s == 0) ? 7'h00 : (f7s == 1) ? 7'h20 : 7'($urandom);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), op, 3'($urandom), f7, "random");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
